hand_receiver: RTL and testbench

HAND_RECEIVER -- requirements
Module: hand_receiver

---
 rtl/bj_pkg.sv | 40 ++++
 rtl/card_value_decoder.sv | 29 ++
 rtl/hand_receiver.sv | 131 +++++++++++++
 tb/tb_hand_receiver.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/bj_pkg.sv
// Shared blackjack definitions: card byte layout, rank codes, scoring
// constants, hand FSM state type and the best-score helpers.
package bj_pkg;

    // Card byte layout: [7:6] deck, [5:4] suit, [3:0] rank
    localparam int CARD_RANK_LSB = 0;
    localparam int CARD_RANK_MSB = 3;
    localparam int CARD_SUIT_LSB = 4;
    localparam int CARD_SUIT_MSB = 5;
    localparam int CARD_DECK_LSB = 6;
    localparam int CARD_DECK_MSB = 7;

    // Rank codes; 0 is the dealer's exhausted-deck code, 14..15 never dealt
    localparam logic [3:0] RANK_NONE = 4'd0;
    localparam logic [3:0] RANK_ACE  = 4'd1;
    localparam logic [3:0] RANK_TEN  = 4'd10;
    localparam logic [3:0] RANK_KING = 4'd13;

    localparam logic [4:0] BJ_TARGET = 5'd21;
    localparam logic [4:0] ACE_BONUS = 5'd10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DECIDE,
        ST_DONE
    } state_e;

    // One ace may count as 11 only while that keeps the hand at or below 21.
    // The largest reachable hard sum is 30, so hard + bonus never wraps.
    function automatic logic is_soft(input logic [4:0] hard, input logic ace);
        return ace && (hard <= (BJ_TARGET - ACE_BONUS));
    endfunction

    function automatic logic [4:0] best_score(input logic [4:0] hard, input logic ace);
        return is_soft(hard, ace) ? (hard + ACE_BONUS) : hard;
    endfunction

endpackage

// File: rtl/card_value_decoder.sv
// Rank-to-value decode: aces count 1 (bonus applied later), faces count 10,
// rank 0 and 14..15 are flagged invalid with a zero value.
module card_value_decoder
    import bj_pkg::*;
(
    input  logic [3:0] rank_i,
    output logic [3:0] value_o,
    output logic       is_ace_o,
    output logic       invalid_o
);

    // Pure lookup on the rank nibble
    always_comb begin
        value_o   = 4'd0;
        is_ace_o  = 1'b0;
        invalid_o = 1'b0;
        if (rank_i == RANK_NONE || rank_i > RANK_KING) begin
            invalid_o = 1'b1;
        end else if (rank_i == RANK_ACE) begin
            value_o  = 4'd1;
            is_ace_o = 1'b1;
        end else if (rank_i >= RANK_TEN) begin
            value_o = RANK_TEN;
        end else begin
            value_o = rank_i;
        end
    end

endmodule

// File: rtl/hand_receiver.sv
// Player-side hand tracker: requests cards from the dealer, accumulates the
// hand, and closes it on stand, bust, 21, card limit or an invalid card.
module hand_receiver
    import bj_pkg::*;
#(
    parameter int MAX_CARDS = 11
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       hit_i,
    input  logic       stand_i,
    input  logic [7:0] card_i,
    output logic       request_card_o,
    output logic [4:0] score_o,
    output logic       soft_o,
    output logic [3:0] card_count_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       bust_o,
    output logic       blackjack_o,
    output logic       error_o
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_CARDS);

    state_e     state_q;
    logic [4:0] hard_q;
    logic       ace_q;
    logic [3:0] count_q;
    logic       bust_q;
    logic       bj_q;
    logic       err_q;

    logic [3:0] card_val;
    logic       card_ace;
    logic       card_bad;
    logic [4:0] hard_d;
    logic       ace_d;
    logic [3:0] count_d;
    logic [4:0] score_d;

    // Deck and suit are carried on the bus but play no part in scoring
    logic unused_card_bits;
    assign unused_card_bits = ^card_i[CARD_DECK_MSB:CARD_SUIT_LSB];

    card_value_decoder u_dec (
        .rank_i   (card_i[CARD_RANK_MSB:CARD_RANK_LSB]),
        .value_o  (card_val),
        .is_ace_o (card_ace),
        .invalid_o(card_bad)
    );

    // Hand as it would stand if the card on the bus were accepted this cycle
    always_comb begin
        hard_d  = hard_q + {1'b0, card_val};
        ace_d   = ace_q | card_ace;
        count_d = count_q + 4'd1;
        score_d = best_score(hard_d, ace_d);
    end

    // Hand FSM; all outputs decode from these registers, so reset clears
    // them (including the card request) without waiting for a clock
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            hard_q  <= '0;
            ace_q   <= 1'b0;
            count_q <= '0;
            bust_q  <= 1'b0;
            bj_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        hard_q  <= '0;
                        ace_q   <= 1'b0;
                        count_q <= '0;
                        bust_q  <= 1'b0;
                        bj_q    <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (card_bad) begin
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        hard_q  <= hard_d;
                        ace_q   <= ace_d;
                        count_q <= count_d;
                        if (score_d > BJ_TARGET) begin
                            bust_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else if (score_d == BJ_TARGET) begin
                            // A natural only counts on the initial two-card deal
                            bj_q    <= (count_d == 4'd2);
                            state_q <= ST_DONE;
                        end else if (count_d == MAX_CNT) begin
                            state_q <= ST_DONE;
                        end else if (count_d < 4'd2) begin
                            state_q <= ST_REQ;
                        end else begin
                            state_q <= ST_DECIDE;
                        end
                    end
                end
                ST_DECIDE: begin
                    // Stand wins when both are raised together
                    if (stand_i)    state_q <= ST_DONE;
                    else if (hit_i) state_q <= ST_REQ;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign request_card_o = (state_q == ST_REQ);
    assign busy_o         = (state_q == ST_REQ) || (state_q == ST_WAIT) || (state_q == ST_DECIDE);
    assign done_o         = (state_q == ST_DONE);
    assign score_o        = best_score(hard_q, ace_q);
    assign soft_o         = is_soft(hard_q, ace_q);
    assign card_count_o   = count_q;
    assign bust_o         = bust_q;
    assign blackjack_o    = bj_q;
    assign error_o        = err_q;

endmodule

// File: tb/tb_hand_receiver.sv
// Directed bench for hand_receiver with a one-cycle-latency dealer model.
module tb_hand_receiver;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic       hit_i;
    logic       stand_i;
    logic [7:0] card_i = 8'h00;
    logic       request_card_o;
    logic [4:0] score_o;
    logic       soft_o;
    logic [3:0] card_count_o;
    logic       busy_o;
    logic       done_o;
    logic       bust_o;
    logic       blackjack_o;
    logic       error_o;

    int n_chk  = 0;
    int n_fail = 0;
    int req_total = 0;
    int base;
    logic [7:0] deck[$];

    always #5 clk_i = ~clk_i;

    hand_receiver #(.MAX_CARDS(11)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .hit_i         (hit_i),
        .stand_i       (stand_i),
        .card_i        (card_i),
        .request_card_o(request_card_o),
        .score_o       (score_o),
        .soft_o        (soft_o),
        .card_count_o  (card_count_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .bust_o        (bust_o),
        .blackjack_o   (blackjack_o),
        .error_o       (error_o)
    );

    // Dealer: registers the next card on the request edge; empty deck gives 0
    always @(posedge clk_i) begin
        if (request_card_o) begin
            req_total++;
            if (deck.size() > 0) card_i <= deck.pop_front();
            else                 card_i <= 8'h00;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic do_start();
        start_i = 1'b1;
        cyc(1);
        start_i = 1'b0;
    endtask

    task automatic do_hit();
        hit_i = 1'b1;
        cyc(1);
        hit_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!done_o && k < 30) begin
            cyc(1);
            k++;
        end
        chk({tag, "_done_reached"}, 32'(done_o), 32'd1);
    endtask

    initial begin
        rst_i = 1'b0; start_i = 1'b0; hit_i = 1'b0; stand_i = 1'b0;
        #12;
        chk("reset_outputs", {request_card_o, score_o, soft_o, card_count_o, busy_o,
                              done_o, bust_o, blackjack_o, error_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        cyc(3);
        chk("idle_hold", {busy_o, done_o, request_card_o}, 32'd0);
        chk("idle_no_req", req_total, 0);

        // Natural blackjack: Q + A
        deck.push_back(8'h0C); deck.push_back(8'h11);
        base = req_total;
        do_start();
        wait_done("bj");
        chk("bj_score", score_o, 21);
        chk("bj_soft", soft_o, 1);
        chk("bj_flag", blackjack_o, 1);
        chk("bj_count", card_count_o, 2);
        chk("bj_reqs", req_total - base, 2);
        chk("bj_nobust", {bust_o, error_o, busy_o}, 0);

        // 5 + 6, hit 10 -> 21 closes without blackjack
        deck.push_back(8'h05); deck.push_back(8'h16); deck.push_back(8'h2A);
        base = req_total;
        do_start();
        cyc(4);
        chk("h21_decide", {busy_o, done_o, score_o, card_count_o}, {1'b1, 1'b0, 5'd11, 4'd2});
        do_hit();
        wait_done("h21");
        chk("h21_score", score_o, 21);
        chk("h21_nobj", blackjack_o, 0);
        chk("h21_count", card_count_o, 3);
        chk("h21_reqs", req_total - base, 3);

        // 10 + 6, hit 8 -> bust at 24; later hit ignored
        deck.push_back(8'h0A); deck.push_back(8'h36); deck.push_back(8'h08);
        do_start();
        cyc(4);
        chk("bust_pre_score", score_o, 16);
        do_hit();
        wait_done("bust");
        chk("bust_score", score_o, 24);
        chk("bust_flag", {bust_o, blackjack_o, card_count_o}, {1'b1, 1'b0, 4'd3});
        base = req_total;
        hit_i = 1'b1;
        cyc(3);
        hit_i = 1'b0;
        chk("bust_hit_ignored", req_total - base, 0);
        chk("bust_hold", {done_o, score_o}, {1'b1, 5'd24});

        // A + A soft 12, hit 10 -> hard 12, then hit+stand closes
        deck.push_back(8'h01); deck.push_back(8'h21); deck.push_back(8'h3A);
        do_start();
        cyc(4);
        chk("aa_soft", {score_o, soft_o}, {5'd12, 1'b1});
        do_hit();
        cyc(2);
        chk("aa_hard", {busy_o, score_o, soft_o, card_count_o}, {1'b1, 5'd12, 1'b0, 4'd3});
        base = req_total;
        hit_i = 1'b1; stand_i = 1'b1;
        cyc(1);
        hit_i = 1'b0; stand_i = 1'b0;
        chk("aa_stand_done", done_o, 1);
        cyc(2);
        chk("aa_stand_noreq", req_total - base, 0);

        // Exhausted deck on the first card
        deck.push_back(8'h00);
        base = req_total;
        do_start();
        wait_done("err");
        chk("err_flag", {error_o, card_count_o, score_o}, {1'b1, 4'd0, 5'd0});
        chk("err_reqs", req_total - base, 1);

        // Reset while waiting for the second card
        deck.push_back(8'h07); deck.push_back(8'h09);
        do_start();
        cyc(3);
        chk("rst_pre", {busy_o, score_o}, {1'b1, 5'd7});
        #2 rst_i = 1'b0;
        #1;
        chk("rst_async", {request_card_o, score_o, soft_o, card_count_o, busy_o,
                          done_o, bust_o, blackjack_o, error_o}, 32'd0);
        cyc(1);
        rst_i = 1'b1;
        cyc(2);
        deck.push_back(8'h07); deck.push_back(8'h19);
        base = req_total;
        do_start();
        cyc(4);
        chk("rst_redeal", {busy_o, done_o, card_count_o, score_o}, {1'b1, 1'b0, 4'd2, 5'd16});
        chk("rst_redeal_reqs", req_total - base, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
